mplier_arbiter: RTL and testbench



---
 rtl/mplier_arbiter_pkg.sv | 26 ++
 rtl/signed_array_mplier.sv | 39 +++
 rtl/mplier_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mplier_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mplier_arbiter_pkg.sv
// rtl/mplier_arbiter_pkg.sv - shared types and helpers for the multiplier arbiter
//
// Purpose: FSM state encoding, ID/counter width helper and the parameter
// legality check used by mplier_arbiter.
// Ports: none (package).
package mplier_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int MIN_NREQ      = 2;
  localparam int MIN_MC_CYCLES = 1;

  // Width needed to index n items; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int nreq, input int mc_cycles);
    return (nreq >= MIN_NREQ) && (mc_cycles >= MIN_MC_CYCLES);
  endfunction

endpackage

// File: rtl/signed_array_mplier.sv
// rtl/signed_array_mplier.sv - combinational N x N -> 2N two's-complement array multiplier
//
// Purpose: exact signed product of i_mcand and i_mplier, built as a ripple
// chain of shifted partial products.
// Ports:
//   i_mcand   [N-1:0]   signed multiplicand
//   i_mplier  [N-1:0]   signed multiplier
//   o_product [2N-1:0]  signed product
module signed_array_mplier #(
  parameter int N = 32
) (
  input  logic [N-1:0]   i_mcand,
  input  logic [N-1:0]   i_mplier,
  output logic [2*N-1:0] o_product
);

  logic [2*N-1:0] w_mcand_ext;
  logic [2*N-1:0] w_pp  [N];
  logic [2*N-1:0] w_sum [N];

  assign w_mcand_ext = {{N{i_mcand[N-1]}}, i_mcand};

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_pp
      assign w_pp[i] = i_mplier[i] ? (w_mcand_ext << i) : '0;
    end

    assign w_sum[0] = '0;
    for (i = 0; i < N - 1; i++) begin : g_row
      assign w_sum[i+1] = w_sum[i] + w_pp[i];
    end
  endgenerate

  // The multiplier MSB carries weight -2^(N-1), so its row is subtracted.
  // Everything is modulo 2^2N, which makes (-2^(N-1))^2 come out exact.
  assign o_product = w_sum[N-1] - w_pp[N-1];

endmodule

// File: rtl/mplier_arbiter.sv
// rtl/mplier_arbiter.sv - round-robin front end sharing one multicycle signed multiplier
//
// Purpose: grants one of NREQ requesters, registers its operands, holds them
// for MC_CYCLES cycles (multicycle path op_* -> rsp_product), then returns
// the registered 2N-bit product on a tagged valid/ready response channel.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready [NREQ]  per-requester handshake (ready is one-hot)
//   req_mcand/req_mplier        packed operands, requester k at [k*N +: N]
//   rsp_valid/rsp_ready         response handshake
//   rsp_id [IDW]                owner of the product
//   rsp_product [2N]            signed product
//   busy                        high whenever not IDLE
module mplier_arbiter
  import mplier_arbiter_pkg::*;
#(
  parameter int N         = 32,
  parameter int NREQ      = 2,
  parameter int MC_CYCLES = 4,
  parameter int IDW       = id_width(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_mcand,
  input  logic [NREQ*N-1:0]   req_mplier,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*N-1:0]      rsp_product,
  output logic                busy
);

  localparam int CNTW = id_width(MC_CYCLES);

  generate
    if (!params_ok(NREQ, MC_CYCLES)) begin : g_bad_params
      $error("mplier_arbiter: NREQ must be >= 2 and MC_CYCLES >= 1");
    end
  endgenerate

  state_t          r_state;
  state_t          w_next_state;
  logic [IDW-1:0]  r_last_grant;
  logic [IDW-1:0]  r_id;
  logic [CNTW-1:0] r_cnt;
  logic [N-1:0]    r_op_mcand;
  logic [N-1:0]    r_op_mplier;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [2*N-1:0]  r_rsp_product;
  logic [2*N-1:0]  w_product;
  logic [IDW:0]    w_pick;
  logic            w_found;
  logic [IDW-1:0]  w_grant;

  // Rotate so the slot after last_grant sits at bit 0, take the lowest set
  // bit, then map the rotated index back to a requester number.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  last);
    logic [NREQ-1:0] rot;
    logic [IDW:0]    res;
    int              base;
    base = (int'(last) + 1) % NREQ;
    for (int k = 0; k < NREQ; k++) begin
      rot[k] = valid[(base + k) % NREQ];
    end
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        res = {1'b1, IDW'((base + k) % NREQ)};
      end
    end
    return res;
  endfunction

  assign w_pick  = rr_pick(req_valid, r_last_grant);
  assign w_found = w_pick[IDW];
  assign w_grant = w_pick[IDW-1:0];

  signed_array_mplier #(.N(N)) u_mplier (
    .i_mcand   (r_op_mcand),
    .i_mplier  (r_op_mplier),
    .o_product (w_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          req_ready[w_grant] = 1'b1;
          w_next_state       = ST_MUL;
        end
      end
      ST_MUL: begin
        if (r_cnt == '0) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant  <= IDW'(NREQ - 1);
      r_id          <= '0;
      r_cnt         <= '0;
      r_op_mcand    <= '0;
      r_op_mplier   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_op_mcand   <= req_mcand[w_grant*N +: N];
            r_op_mplier  <= req_mplier[w_grant*N +: N];
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= CNTW'(MC_CYCLES - 1);
          end
        end
        ST_MUL: begin
          if (r_cnt == '0) begin
            r_rsp_product <= w_product;
            r_rsp_id      <= r_id;
            r_rsp_valid   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_product = r_rsp_product;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mplier_arbiter.sv
// tb/tb_mplier_arbiter.sv - directed self-checking bench for mplier_arbiter
module tb_mplier_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 2;
  localparam int MC   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_mcand = '0;
  logic [NREQ*N-1:0] req_mplier = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [0:0]        rsp_id;
  logic [2*N-1:0]    rsp_product;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  mplier_arbiter #(.N(N), .NREQ(NREQ), .MC_CYCLES(MC)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mcand   (req_mcand),
    .req_mplier  (req_mplier),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request on requester k and wait (bounded) until it is accepted.
  // Returns one cycle after acceptance, with req_valid dropped.
  task automatic launch(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
    int n;
    req_mcand[k*N +: N]  = a;
    req_mplier[k*N +: N] = b;
    req_valid[k]         = 1'b1;
    #1;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (!req_ready[k]) begin
      miscompares++;
      $display("FAIL launch_accept req%0d: req_ready=%b, required bit %0d set", k, req_ready, k);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    vectors++; if (rsp_product !== 16'h0000) begin miscompares++; $display("FAIL reset_rsp_product: got %h want 0000", rsp_product); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    req_mcand[0 +: N]  = 8'hFD;
    req_mplier[0 +: N] = 8'd5;
    req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL single_accept: req_ready=%b want 01", req_ready); end
    tick();
    req_valid = '0;
    for (int c = 1; c <= 5; c++) begin
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy c%0d: got %b want 1", c, busy); end
      vectors++; if (rsp_valid !== (c == 5)) begin miscompares++; $display("FAIL single_rsp_valid c%0d: got %b want %b", c, rsp_valid, (c == 5)); end
      if (c < 5) tick();
    end
    vectors++; if (rsp_product !== 16'hFFF1) begin miscompares++; $display("FAIL single_product: got %h want fff1", rsp_product); end
    vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    tick();
    vectors++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle_c6: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
  endtask

  task automatic test_corner();
    logic [N-1:0]   ta [4];
    logic [N-1:0]   tb [4];
    logic [2*N-1:0] te [4];
    int cyc;
    ta[0] = 8'h80; tb[0] = 8'h80; te[0] = 16'h4000;
    ta[1] = 8'h7F; tb[1] = 8'h80; te[1] = 16'hC080;
    ta[2] = 8'h00; tb[2] = 8'hFF; te[2] = 16'h0000;
    ta[3] = 8'hFF; tb[3] = 8'hFF; te[3] = 16'h0001;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      launch(0, ta[i], tb[i]);
      wait_rsp(cyc);
      vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL corner%0d_latency: got %0d want 4", i, cyc); end
      vectors++; if (rsp_product !== te[i]) begin miscompares++; $display("FAIL corner%0d_product: got %h want %h", i, rsp_product, te[i]); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    int last_cyc;
    int n;
    logic [NREQ-1:0] want;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_mcand  = {8'hFC, 8'd2};
    req_mplier = {8'd7,  8'd3};
    req_valid  = 2'b11;
    #1;
    cyc = 0;
    last_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (req_ready == '0 && n < 20) begin
        tick();
        cyc++;
        n++;
      end
      want = (g % 2 == 0) ? 2'b01 : 2'b10;
      vectors++; if (req_ready !== want) begin miscompares++; $display("FAIL rr_grant%0d: req_ready=%b want %b", g, req_ready, want); end
      if (g > 0) begin
        vectors++; if (cyc - last_cyc !== 6) begin miscompares++; $display("FAIL rr_spacing%0d: got %0d want 6", g, cyc - last_cyc); end
      end
      last_cyc = cyc;
      tick();
      cyc++;
    end
    req_valid = '0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_back_pressure();
    int cyc;
    rsp_ready = 1'b0;
    launch(1, 8'd9, 8'hFE);
    req_mcand[0 +: N]  = 8'd3;
    req_mplier[0 +: N] = 8'd3;
    req_valid = 2'b01;
    wait_rsp(cyc);
    vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL bp_latency: got %0d want 4", cyc); end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_product !== 16'hFFEE || rsp_id !== 1'b1 || req_ready !== 2'b00) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid=%b product=%h id=%0d req_ready=%b want 1 ffee 1 00",
                 i, rsp_valid, rsp_product, rsp_id, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_handshake_ready: got %b want 00", req_ready); end
    tick();
    vectors++; if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin miscompares++; $display("FAIL bp_next_accept: rsp_valid=%b req_ready=%b want 0 01", rsp_valid, req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(cyc);
    vectors++; if (rsp_product !== 16'h0009 || rsp_id !== 1'b0) begin miscompares++; $display("FAIL bp_second_rsp: product=%h id=%0d want 0009 0", rsp_product, rsp_id); end
    tick();
  endtask

  task automatic test_operand_change();
    int cyc;
    rsp_ready = 1'b1;
    launch(0, 8'd5, 8'd6);
    req_mcand[0 +: N]  = 8'd100;
    req_mplier[0 +: N] = 8'hFF;
    wait_rsp(cyc);
    vectors++; if (rsp_product !== 16'h001E) begin miscompares++; $display("FAIL opchange_product: got %h want 001e", rsp_product); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    rsp_ready = 1'b1;
    launch(1, 8'd11, 8'd11);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_product !== 16'h0000 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL midrst_outputs: busy=%b valid=%b product=%h id=%0d req_ready=%b want all 0",
               busy, rsp_valid, rsp_product, rsp_id, req_ready);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midrst_no_rsp: rsp_valid cycles=%0d want 0", seen); end
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL midrst_tie: req_ready=%b want 01", req_ready); end
    tick();
    req_valid = '0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_corner();
    test_round_robin();
    test_back_pressure();
    test_operand_change();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
